// File: rtl/wfifo_pkt_ingress.sv
// Write-side packet ingress for the async FIFO: admits whole packets only,
// drives winc/wdata, and reports fill level, almost-full, errors and count.
module wfifo_pkt_ingress #(
    parameter int unsigned DSIZE     = 8,
    parameter int unsigned ADDRSIZE  = 4,
    parameter int unsigned AF_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DSIZE-1:0]    s_data,
    input  logic                s_last,
    input  logic [ADDRSIZE:0]   s_len,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic                winc,
    output logic [DSIZE-1:0]    wdata,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic                len_err,
    output logic [15:0]         pkt_cnt
);

    localparam int unsigned PW    = ADDRSIZE + 1;
    localparam int unsigned DEPTH = 1 << ADDRSIZE;

    typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

    state_t          state;
    logic [PW-1:0]   remaining;
    logic [PW-1:0]   wb;
    logic [PW-1:0]   rb;
    logic [PW-1:0]   lvl;
    logic [PW-1:0]   free;
    logic            len_bad;
    logic            accept;

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Modulo subtraction keeps the level correct across pointer wrap
    assign wb      = gray2bin(wptr);
    assign rb      = gray2bin(wq2_rptr);
    assign lvl     = wb - rb;
    assign free    = PW'(DEPTH) - lvl;
    assign len_bad = (s_len == '0) || (s_len > PW'(DEPTH));

    // Handshake and write path are combinational so beats stream back-to-back
    assign s_ready = ((state == XFER) && !wfull) || (state == DROP);
    assign accept  = s_valid && s_ready;
    assign winc    = (state == XFER) && accept;
    assign wdata   = s_data;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state        <= IDLE;
            remaining    <= '0;
            wlevel       <= '0;
            walmost_full <= 1'b0;
            len_err      <= 1'b0;
            pkt_cnt      <= '0;
        end else begin
            wlevel       <= lvl;
            walmost_full <= (lvl >= PW'(AF_THRESH));
            len_err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid && len_bad) begin
                        len_err <= 1'b1;
                        state   <= DROP;
                    end else if (s_valid && (s_len <= free)) begin
                        remaining <= s_len;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (accept) begin
                        remaining <= remaining - PW'(1);
                        if (s_last && (remaining == PW'(1))) begin
                            if (pkt_cnt != 16'hFFFF) begin
                                pkt_cnt <= pkt_cnt + 16'd1;
                            end
                            state <= IDLE;
                        end else if (s_last) begin
                            len_err <= 1'b1;
                            state   <= IDLE;
                        end else if (remaining == PW'(1)) begin
                            len_err <= 1'b1;
                            state   <= DROP;
                        end
                    end
                end
                DROP: begin
                    if (accept && s_last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wfifo_pkt_ingress.sv
// Directed bench for wfifo_pkt_ingress; models the write-pointer block and
// the synchronized read pointer as plain binary counters converted to Gray.
module tb_wfifo_pkt_ingress;

    logic        wclk = 1'b0;
    logic        wrst_n;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic [4:0]  s_len;
    logic        wfull;
    logic [4:0]  wptr;
    logic [4:0]  wq2_rptr;
    logic        winc;
    logic [7:0]  wdata;
    logic [4:0]  wlevel;
    logic        walmost_full;
    logic        len_err;
    logic [15:0] pkt_cnt;

    logic [4:0]  wb;
    logic [4:0]  rb;
    int          checks = 0;
    int          fails  = 0;

    wfifo_pkt_ingress #(.DSIZE(8), .ADDRSIZE(4), .AF_THRESH(12)) dut (
        .wclk(wclk), .wrst_n(wrst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .s_len(s_len),
        .wfull(wfull), .wptr(wptr), .wq2_rptr(wq2_rptr),
        .winc(winc), .wdata(wdata), .wlevel(wlevel),
        .walmost_full(walmost_full), .len_err(len_err), .pkt_cnt(pkt_cnt)
    );

    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
            $error("assertion %s", tag);
        end
    endtask

    task automatic update_ptrs();
        wptr     = wb ^ (wb >> 1);
        wq2_rptr = rb ^ (rb >> 1);
        wfull    = ((wb - rb) == 5'd16);
    endtask

    // One clock: the write-pointer model advances one cycle after winc
    task automatic step();
        logic w;
        w = winc;
        @(posedge wclk);
        #1;
        if (w) wb = wb + 5'd1;
        update_ptrs();
    endtask

    task automatic send_beat(input string tag, input logic [7:0] d, input logic last,
                             input logic exp_winc);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        #1;
        chk({tag, "_winc"}, 32'(winc), 32'(exp_winc));
        if (exp_winc) chk({tag, "_wdata"}, 32'(wdata), 32'(d));
        step();
    endtask

    task automatic drop_pkt(input string tag, input logic [4:0] len);
        s_valid = 1'b1;
        s_len   = len;
        s_data  = 8'h55;
        s_last  = 1'b0;
        #1;
        chk({tag, "_idle_rdy"}, 32'(s_ready), 32'd0);
        step();
        chk({tag, "_err"}, 32'(len_err), 32'd1);
        chk({tag, "_drop_rdy"}, 32'(s_ready), 32'd1);
        chk({tag, "_drop_winc"}, 32'(winc), 32'd0);
        step();
        chk({tag, "_err_clr"}, 32'(len_err), 32'd0);
        send_beat({tag, "_b2"}, 8'h56, 1'b0, 1'b0);
        send_beat({tag, "_b3"}, 8'h57, 1'b1, 1'b0);
        s_valid = 1'b0;
        #1;
        chk({tag, "_back_idle"}, 32'(s_ready), 32'd0);
        chk({tag, "_cnt"}, 32'(pkt_cnt), 32'd2);
    endtask

    initial begin
        wrst_n  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        s_len   = '0;
        wb      = '0;
        rb      = '0;
        update_ptrs();
        #2;
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_wlevel", 32'(wlevel), 32'd0);
        chk("rst_af", 32'(walmost_full), 32'd0);
        chk("rst_lenerr", 32'(len_err), 32'd0);
        chk("rst_pktcnt", 32'(pkt_cnt), 32'd0);
        @(negedge wclk);
        wrst_n = 1'b1;
        step();

        // Basic 4-beat packet into an empty FIFO
        s_valid = 1'b1;
        s_len   = 5'd4;
        s_data  = 8'hA0;
        #1;
        chk("p1_adm_wait", 32'(s_ready), 32'd0);
        step();
        chk("p1_ready", 32'(s_ready), 32'd1);
        for (int b = 0; b < 4; b++) begin
            send_beat("p1_beat", 8'(8'hA0 + b), (b == 3), 1'b1);
        end
        s_valid = 1'b0;
        #1;
        chk("p1_cnt", 32'(pkt_cnt), 32'd1);
        chk("p1_lvl_lag", 32'(wlevel), 32'd3);
        step();
        chk("p1_lvl", 32'(wlevel), 32'd4);

        // Level 14: 3-beat packet must wait until one more slot frees up
        rb = 5'd22;
        update_ptrs();
        step();
        chk("p2_lvl14", 32'(wlevel), 32'd14);
        chk("p2_af14", 32'(walmost_full), 32'd1);
        s_valid = 1'b1;
        s_len   = 5'd3;
        s_data  = 8'hB0;
        s_last  = 1'b0;
        step();
        step();
        chk("p2_held_rdy", 32'(s_ready), 32'd0);
        chk("p2_held_winc", 32'(winc), 32'd0);
        rb = 5'd23;
        update_ptrs();
        #1;
        chk("p2_adm_wait", 32'(s_ready), 32'd0);
        step();
        chk("p2_ready", 32'(s_ready), 32'd1);
        for (int b = 0; b < 3; b++) begin
            send_beat("p2_beat", 8'(8'hB0 + b), (b == 2), 1'b1);
        end
        s_valid = 1'b0;
        step();
        chk("p2_lvl16", 32'(wlevel), 32'd16);
        chk("p2_af16", 32'(walmost_full), 32'd1);
        chk("p2_cnt", 32'(pkt_cnt), 32'd2);
        rb = wb;
        update_ptrs();
        step();
        chk("p2_drain_lvl", 32'(wlevel), 32'd0);
        chk("p2_drain_af", 32'(walmost_full), 32'd0);

        // Illegal lengths are consumed without writing
        drop_pkt("len0", 5'd0);
        drop_pkt("len17", 5'd17);

        // Short packet: 4 declared, 2 delivered
        s_valid = 1'b1;
        s_len   = 5'd4;
        step();
        send_beat("short_b1", 8'hC0, 1'b0, 1'b1);
        send_beat("short_b2", 8'hC1, 1'b1, 1'b1);
        s_valid = 1'b0;
        #1;
        chk("short_err", 32'(len_err), 32'd1);
        chk("short_idle", 32'(s_ready), 32'd0);
        chk("short_cnt", 32'(pkt_cnt), 32'd2);

        // Long packet: 2 declared, 4 delivered, tail dropped
        s_valid = 1'b1;
        s_len   = 5'd2;
        step();
        send_beat("long_b1", 8'hD0, 1'b0, 1'b1);
        send_beat("long_b2", 8'hD1, 1'b0, 1'b1);
        chk("long_err", 32'(len_err), 32'd1);
        chk("long_drop_rdy", 32'(s_ready), 32'd1);
        send_beat("long_b3", 8'hD2, 1'b0, 1'b0);
        send_beat("long_b4", 8'hD3, 1'b1, 1'b0);
        s_valid = 1'b0;
        #1;
        chk("long_idle", 32'(s_ready), 32'd0);
        chk("long_cnt", 32'(pkt_cnt), 32'd2);
        step();
        step();
        chk("long_lvl", 32'(wlevel), 32'd4);

        // Pointer wrap: wb 30 -> 2 with rb 26
        wb = 5'd30;
        rb = 5'd26;
        update_ptrs();
        s_valid = 1'b1;
        s_len   = 5'd4;
        s_last  = 1'b0;
        step();
        chk("wrap_lvl0", 32'(wlevel), 32'd4);
        for (int b = 0; b < 4; b++) begin
            send_beat("wrap_beat", 8'(8'hE0 + b), (b == 3), 1'b1);
            chk("wrap_lvl", 32'(wlevel), 32'(4 + b));
        end
        s_valid = 1'b0;
        step();
        chk("wrap_lvl_end", 32'(wlevel), 32'd8);
        chk("wrap_wb", 32'(wb), 32'd2);
        chk("wrap_cnt", 32'(pkt_cnt), 32'd3);

        // Reset in the middle of a 5-beat packet
        s_valid = 1'b1;
        s_len   = 5'd5;
        step();
        send_beat("rstm_b1", 8'hF0, 1'b0, 1'b1);
        send_beat("rstm_b2", 8'hF1, 1'b0, 1'b1);
        wrst_n = 1'b0;
        #1;
        chk("rstm_ready", 32'(s_ready), 32'd0);
        chk("rstm_winc", 32'(winc), 32'd0);
        chk("rstm_wlevel", 32'(wlevel), 32'd0);
        chk("rstm_af", 32'(walmost_full), 32'd0);
        chk("rstm_cnt", 32'(pkt_cnt), 32'd0);
        s_valid = 1'b0;
        #1;
        wrst_n = 1'b1;
        step();
        chk("post_lvl", 32'(wlevel), 32'd10);
        s_valid = 1'b1;
        s_len   = 5'd1;
        #1;
        chk("post_adm_wait", 32'(s_ready), 32'd0);
        step();
        chk("post_ready", 32'(s_ready), 32'd1);
        send_beat("post_b1", 8'h3C, 1'b1, 1'b1);
        s_valid = 1'b0;
        #1;
        chk("post_cnt", 32'(pkt_cnt), 32'd1);
        chk("post_err", 32'(len_err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
